seg7_frame_capture: RTL and testbench

Recovers the hex value shown on a multiplexed, active-low 4-digit seven-segment display by sampling its anode and segment lines. It sits beside the display driver as a self-check and readback path, decoding segment patterns back into 4-bit nibbles. Each time all four digits have been seen, it publishes a 16-bit value with per-digit error flags.

---
 rtl/seg7_frame_capture.sv | 177 +++++++++++++++++
 tb/tb_seg7_frame_capture.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_frame_capture.sv
// ============================================================================
// Module   : seg7_frame_capture
// Purpose  : Reads back a multiplexed active-low 4-digit seven-segment display
//            and publishes the decoded 16-bit value with per-digit error flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_frame_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] frame_value,
  output logic [3:0]  frame_err,
  output logic        frame_valid,
  output logic        frame_timeout
);

  localparam int              TW            = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0]      C_STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0]      C_STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0]   C_TMO_LAST    = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [0:0] {
    ST_ACQUIRE = 1'b0,
    ST_PUBLISH = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [10:0]   sync1_q, sync2_q, prev_q;
  logic [7:0]    stab_q, stab_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    mask_q, mask_d;
  logic [15:0]   stage_val_q;
  logic [3:0]    stage_err_q;
  logic [15:0]   frame_value_q, frame_value_d;
  logic [3:0]    frame_err_q, frame_err_d;
  logic          frame_valid_q, frame_valid_d;
  logic          frame_timeout_q, frame_timeout_d;

  logic [3:0]    an_act;
  logic          one_hot;
  logic          same;
  logic          capture;
  logic [3:0]    cap_bits;
  logic [4:0]    dec;
  logic          mask_full;

  // Returns {err, nibble}; anything outside the hex glyph set is an error.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b0000011: decode = 5'h0B;
      7'b1000110: decode = 5'h0C;
      7'b0100001: decode = 5'h0D;
      7'b0000110: decode = 5'h0E;
      7'b0001110: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  assign an_act   = ~sync2_q[10:7];
  assign one_hot  = (an_act != 4'd0) && ((an_act & (an_act - 4'd1)) == 4'd0);
  assign same     = (sync2_q == prev_q);
  // Fires only on the edge the counter reaches its limit, so a held value is taken once.
  assign capture  = same && (stab_q == C_STABLE_LAST) && one_hot;
  assign cap_bits = capture ? an_act : 4'd0;
  assign dec      = decode(sync2_q[6:0]);
  assign mask_full = ((mask_q | cap_bits) == 4'hF);

  always_comb begin
    stab_d = 8'd1;
    if (same) begin
      stab_d = (stab_q == C_STABLE_MAX) ? stab_q : stab_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 11'h7FF;
      sync2_q     <= 11'h7FF;
      prev_q      <= 11'h7FF;
      stab_q      <= 8'd0;
      stage_val_q <= 16'd0;
      stage_err_q <= 4'd0;
    end else begin
      sync1_q <= {an, seg};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      stab_q  <= stab_d;
      for (int i = 0; i < 4; i++) begin
        if (cap_bits[i]) begin
          stage_val_q[4*i +: 4] <= dec[3:0];
          stage_err_q[i]        <= dec[4];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_ACQUIRE;
      mask_q          <= 4'd0;
      tmo_q           <= '0;
      frame_value_q   <= 16'd0;
      frame_err_q     <= 4'd0;
      frame_valid_q   <= 1'b0;
      frame_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      mask_q          <= mask_d;
      tmo_q           <= tmo_d;
      frame_value_q   <= frame_value_d;
      frame_err_q     <= frame_err_d;
      frame_valid_q   <= frame_valid_d;
      frame_timeout_q <= frame_timeout_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    mask_d          = mask_q;
    tmo_d           = tmo_q;
    frame_value_d   = frame_value_q;
    frame_err_d     = frame_err_q;
    frame_valid_d   = 1'b0;
    frame_timeout_d = 1'b0;
    case (state_q)
      ST_ACQUIRE: begin
        mask_d = mask_q | cap_bits;
        // Completion is checked first so it beats a simultaneous timeout.
        if (mask_full) begin
          state_d = ST_PUBLISH;
        end else if ((mask_q != 4'd0) && (tmo_q == C_TMO_LAST)) begin
          frame_timeout_d = 1'b1;
          mask_d          = cap_bits;
          tmo_d           = '0;
        end else if (mask_q != 4'd0) begin
          tmo_d = tmo_q + 1'b1;
        end else begin
          tmo_d = '0;
        end
      end
      ST_PUBLISH: begin
        frame_value_d = stage_val_q;
        frame_err_d   = stage_err_q;
        frame_valid_d = 1'b1;
        mask_d        = cap_bits;
        tmo_d         = '0;
        state_d       = ST_ACQUIRE;
      end
      default: state_d = ST_ACQUIRE;
    endcase
  end

  assign frame_value   = frame_value_q;
  assign frame_err     = frame_err_q;
  assign frame_valid   = frame_valid_q;
  assign frame_timeout = frame_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_frame_capture.sv
// ============================================================================
// Module   : tb_seg7_frame_capture
// Purpose  : Directed and randomized checks of seg7_frame_capture against a
//            digit-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg7_frame_capture;

  localparam int S = 4;
  localparam int T = 64;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] frame_value;
  logic [3:0]  frame_err;
  logic        frame_valid;
  logic        frame_timeout;

  seg7_frame_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
    .frame_value(frame_value), .frame_err(frame_err),
    .frame_valid(frame_valid), .frame_timeout(frame_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int nvalid = 0, ntmo = 0, both_hi = 0, valid_cyc = -1, tmo_cyc = -1;
  logic [15:0] seen_val = 16'd0;
  logic [3:0]  seen_err = 4'd0;

  always @(negedge clk) begin
    if (frame_valid) begin
      nvalid++; valid_cyc = cyc; seen_val = frame_value; seen_err = frame_err;
    end
    if (frame_timeout) begin
      ntmo++; tmo_cyc = cyc;
    end
    if (frame_valid && frame_timeout) both_hi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] an_of(input int i);
    logic [3:0] one;
    one = 4'd1;
    return ~(one << i);
  endfunction

  function automatic logic [4:0] ref_dec(input logic [6:0] s);
    for (int n = 0; n < 16; n++) if (GLYPH[n] == s) return {1'b0, 4'(n)};
    return 5'h10;
  endfunction

  // Called at a falling edge; leaves the value on the pins for d rising edges.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int d);
    an = a; seg = s;
    repeat (d) @(negedge clk);
  endtask

  task automatic show_frame(input logic [15:0] v, input int d, output int k_last);
    k_last = 0;
    for (int i = 3; i >= 0; i--) begin
      k_last = cyc;
      drive(an_of(i), GLYPH[v[4*i +: 4]], d);
    end
  endtask

  initial begin
    int k, exp_valid, exp_tmo;
    logic [15:0] ev;
    logic [3:0]  ee;
    logic [4:0]  d5;
    logic [6:0]  p;
    int order [4];
    int seq [5];
    int nh, tmp, r;

    repeat (3) @(negedge clk);
    check("reset_value", 32'(frame_value), 32'h0);
    check("reset_err", 32'(frame_err), 32'h0);
    check("reset_valid", 32'(frame_valid), 32'h0);
    check("reset_timeout", 32'(frame_timeout), 32'h0);
    rst_n = 1'b1;
    drive(4'hF, 7'h7F, 4);

    // C0FE with latency check on the last digit
    show_frame(16'hC0FE, 8, k);
    drive(4'hF, 7'h7F, 10);
    check("c0fe_count", 32'(nvalid), 32'd1);
    check("c0fe_value", 32'(seen_val), 32'hC0FE);
    check("c0fe_err", 32'(seen_err), 32'h0);
    check("c0fe_latency", 32'(valid_cyc), 32'(k + 7));

    // Short glitch on digit 1 must not be captured
    drive(an_of(3), GLYPH[12], 8);
    drive(an_of(2), GLYPH[0], 8);
    drive(an_of(1), GLYPH[15], 8);
    drive(an_of(1), GLYPH[3], S - 1);
    drive(an_of(0), GLYPH[14], 8);
    drive(4'hF, 7'h7F, 10);
    check("glitch_count", 32'(nvalid), 32'd2);
    check("glitch_value", 32'(seen_val), 32'hC0FE);

    // Blank digit 2
    drive(an_of(3), GLYPH[1], 8);
    drive(an_of(2), 7'h7F, 8);
    drive(an_of(1), GLYPH[3], 8);
    drive(an_of(0), GLYPH[4], 8);
    drive(4'hF, 7'h7F, 10);
    check("blank_count", 32'(nvalid), 32'd3);
    check("blank_value", 32'(seen_val), 32'h1034);
    check("blank_err", 32'(seen_err), 32'h4);

    // Partial frame times out 63 cycles after its first capture
    k = cyc;
    drive(an_of(0), GLYPH[5], 8);
    drive(an_of(1), GLYPH[6], 8);
    drive(4'hF, 7'h7F, 90);
    check("tmo_count", 32'(ntmo), 32'd1);
    check("tmo_cycle", 32'(tmo_cyc), 32'(k + 6 + T - 1));
    check("tmo_no_valid", 32'(nvalid), 32'd3);
    check("tmo_value_kept", 32'(frame_value), 32'h1034);

    // Two anodes active: nothing captured
    drive(4'b0011, GLYPH[1], 20);
    check("multi_an_mask", 32'(dut.mask_q), 32'h0);
    check("multi_an_valid", 32'(nvalid), 32'd3);
    check("multi_an_tmo", 32'(ntmo), 32'd1);

    // Reset after three captures discards the partial frame
    drive(an_of(3), GLYPH[9], 8);
    drive(an_of(2), GLYPH[9], 8);
    drive(an_of(1), GLYPH[9], 8);
    rst_n = 1'b0;
    #1;
    check("async_rst_value", 32'(frame_value), 32'h0);
    @(negedge clk);
    drive(4'hF, 7'h7F, 2);
    rst_n = 1'b1;
    drive(an_of(0), GLYPH[4], 8);
    drive(4'hF, 7'h7F, 70);
    check("rst_partial_valid", 32'(nvalid), 32'd3);
    check("rst_partial_tmo", 32'(ntmo), 32'd2);
    show_frame(16'h1234, 8, k);
    drive(4'hF, 7'h7F, 10);
    check("rst_frame_count", 32'(nvalid), 32'd4);
    check("rst_frame_value", 32'(seen_val), 32'h1234);
    check("rst_frame_err", 32'(seen_err), 32'h0);

    // Randomized frames: model keeps the last captured pattern per digit
    exp_valid = 4;
    exp_tmo = 2;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 4; i++) order[i] = i;
      for (int i = 3; i > 0; i--) begin
        r = int'($urandom_range(i, 0));
        tmp = order[i]; order[i] = order[r]; order[r] = tmp;
      end
      if ($urandom_range(1, 0) == 1) begin
        nh = 5;
        seq[0] = order[0]; seq[1] = order[1]; seq[2] = order[2];
        seq[3] = order[$urandom_range(2, 0)]; seq[4] = order[3];
      end else begin
        nh = 4;
        for (int i = 0; i < 4; i++) seq[i] = order[i];
      end
      ev = 16'd0; ee = 4'd0;
      for (int j = 0; j < nh; j++) begin
        if ($urandom_range(9, 0) < 3) begin
          if ($urandom_range(1, 0) == 1) drive(an_of(int'($urandom_range(3, 0))), 7'($urandom), int'($urandom_range(S - 1, 1)));
          else drive(4'($urandom), 7'($urandom), int'($urandom_range(S - 1, 1)));
        end
        p = ($urandom_range(3, 0) == 0) ? 7'($urandom) : GLYPH[$urandom_range(15, 0)];
        d5 = ref_dec(p);
        ev[4*seq[j] +: 4] = d5[3:0];
        ee[seq[j]] = d5[4];
        drive(an_of(seq[j]), p, S + int'($urandom_range(3, 0)));
      end
      drive(4'hF, 7'h7F, 10);
      exp_valid++;
      check("rand_count", 32'(nvalid), 32'(exp_valid));
      check("rand_value", 32'(seen_val), 32'(ev));
      check("rand_err", 32'(seen_err), 32'(ee));
    end
    check("rand_no_tmo", 32'(ntmo), 32'(exp_tmo));
    check("never_both_pulses", 32'(both_hi), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
